// File: rtl/ec2_program_loader.sv
// ec2_program_loader: front-end sequencer for the EC2 32x8 instruction/data memory.
// It loads words from the Input switches one Enter press at a time. Finish back-fills
// the remaining addresses with FILL_VALUE. The CPU is held in reset until the memory
// image is complete.
module ec2_program_loader #(
  parameter int                ADDR_W      = 5,
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 32,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_VALUE  = 8'h00
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load_req,
  input  logic              Run_req,
  input  logic              Enter,
  input  logic              Finish,
  input  logic [DATA_W-1:0] Input,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_data,
  output logic              Cpu_reset,
  output logic              Loading,
  output logic              Done,
  output logic [ADDR_W:0]   Count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WRITE,
    WAIT_RELEASE,
    FILL,
    RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t                 state;
  logic [SYNC_STAGES-1:0] enter_sync;
  logic [SYNC_STAGES-1:0] finish_sync;
  logic                   enter_prev;
  logic                   finish_prev;
  logic                   enter_level;
  logic                   enter_edge;
  logic                   finish_edge;

  // Bring the raw pushbuttons into the clock domain and remember their last synchronised level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      enter_sync  <= '0;
      finish_sync <= '0;
      enter_prev  <= 1'b0;
      finish_prev <= 1'b0;
    end else begin
      enter_sync  <= {enter_sync[SYNC_STAGES-2:0], Enter};
      finish_sync <= {finish_sync[SYNC_STAGES-2:0], Finish};
      enter_prev  <= enter_sync[SYNC_STAGES-1];
      finish_prev <= finish_sync[SYNC_STAGES-1];
    end
  end

  // A key press becomes a single-cycle event on the rising edge of its synchronised level.
  always_comb begin
    enter_level = enter_sync[SYNC_STAGES-1];
    enter_edge  = enter_level & ~enter_prev;
    finish_edge = finish_sync[SYNC_STAGES-1] & ~finish_prev;
  end

  // Loader FSM. All outputs are registered and change together with the state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Mem_we    <= 1'b0;
      Mem_addr  <= '0;
      Mem_data  <= '0;
      Cpu_reset <= 1'b1;
      Loading   <= 1'b0;
      Done      <= 1'b0;
      Count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Load_req) begin
            state    <= WAIT_PRESS;
            Mem_addr <= '0;
            Count    <= '0;
            Loading  <= 1'b1;
          end else if (Run_req) begin
            state     <= RUN;
            Cpu_reset <= 1'b0;
            Done      <= 1'b1;
          end
        end

        WAIT_PRESS: begin
          // Enter wins over a Finish event arriving on the same edge; that Finish is dropped.
          if (enter_edge) begin
            state    <= WRITE;
            Mem_we   <= 1'b1;
            Mem_data <= Input;
          end else if (finish_edge) begin
            state    <= FILL;
            Mem_we   <= 1'b1;
            Mem_data <= FILL_VALUE;
          end
        end

        WRITE: begin
          Mem_we <= 1'b0;
          if (Count != MAX_COUNT) begin
            Count <= Count + (ADDR_W + 1)'(1);
          end
          if (Mem_addr == LAST_ADDR) begin
            state     <= RUN;
            Cpu_reset <= 1'b0;
            Loading   <= 1'b0;
            Done      <= 1'b1;
          end else begin
            Mem_addr <= Mem_addr + ADDR_W'(1);
            state    <= WAIT_RELEASE;
          end
        end

        WAIT_RELEASE: begin
          // A held key must be released before it can commit another word.
          if (!enter_level) begin
            state <= WAIT_PRESS;
          end
        end

        FILL: begin
          if (Mem_addr == LAST_ADDR) begin
            state     <= RUN;
            Mem_we    <= 1'b0;
            Cpu_reset <= 1'b0;
            Loading   <= 1'b0;
            Done      <= 1'b1;
          end else begin
            Mem_addr <= Mem_addr + ADDR_W'(1);
          end
        end

        RUN: begin
          if (Load_req) begin
            state     <= WAIT_PRESS;
            Mem_addr  <= '0;
            Count     <= '0;
            Cpu_reset <= 1'b1;
            Loading   <= 1'b1;
            Done      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          Mem_we    <= 1'b0;
          Cpu_reset <= 1'b1;
          Loading   <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ec2_program_loader.sv
// Self-checking bench for ec2_program_loader. A monitor records every memory write.
// The expected write sequences come from the load rules: user words at increasing
// addresses, followed by a FILL_VALUE back-fill up to the last address.
module tb_ec2_program_loader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam logic [DATA_W-1:0] FILL = 8'h00;

  logic              Clock;
  logic              Reset;
  logic              Load_req;
  logic              Run_req;
  logic              Enter;
  logic              Finish;
  logic [DATA_W-1:0] Input;
  logic              Mem_we;
  logic [ADDR_W-1:0] Mem_addr;
  logic [DATA_W-1:0] Mem_data;
  logic              Cpu_reset;
  logic              Loading;
  logic              Done;
  logic [ADDR_W:0]   Count;

  ec2_program_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2), .FILL_VALUE(FILL)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Load_req(Load_req), .Run_req(Run_req),
    .Enter(Enter), .Finish(Finish), .Input(Input),
    .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_data(Mem_data),
    .Cpu_reset(Cpu_reset), .Loading(Loading), .Done(Done), .Count(Count)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int n_words;
    bit finish;
    int exp_count;
    int exp_writes;
  } vec_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  bad_we = 0;
  int  bad_rst = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observe the memory write port and global output invariants at each active edge.
  always @(posedge Clock) begin
    if (Mem_we === 1'b1) begin
      obs_q.push_back('{addr: Mem_addr, data: Mem_data});
      if (Done === 1'b1 || Loading !== 1'b1) bad_we++;
    end
    if (Reset === 1'b0 && Cpu_reset !== ~Done) bad_rst++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic compare_writes(input string name);
    int bad;
    bad = 0;
    check({name, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) bad++;
    end
    check({name, "_seq_mismatches"}, bad, 0);
  endtask

  task automatic pulse_load();
    Load_req = 1'b1;
    step(1);
    Load_req = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Press Enter with data d; Input is scrambled after the capture edge while the key stays held.
  task automatic press_word(input logic [DATA_W-1:0] d);
    Input = d;
    Enter = 1'b1;
    step(3);
    Input = DATA_W'($urandom);
    step($urandom_range(0, 4));
    Enter = 1'b0;
    step($urandom_range(2, 4));
  endtask

  task automatic pulse_finish();
    Finish = 1'b1;
    step(1);
    Finish = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      if (Done === 1'b1) break;
      step(1);
    end
    check({name, "_done"}, Done, 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] hold_v[50];
    int lat;
    bit found;

    vecs[0] = '{n_words: 3,  finish: 1'b1, exp_count: 3,  exp_writes: 32};
    vecs[1] = '{n_words: 0,  finish: 1'b1, exp_count: 0,  exp_writes: 32};
    vecs[2] = '{n_words: 32, finish: 1'b0, exp_count: 32, exp_writes: 32};
    vecs[3] = '{n_words: 31, finish: 1'b1, exp_count: 31, exp_writes: 32};
    vecs[4] = '{n_words: 1,  finish: 1'b1, exp_count: 1,  exp_writes: 32};

    Reset = 1'b1; Load_req = 0; Run_req = 0; Enter = 0; Finish = 0; Input = '0;
    step(2);
    check("rst_cpu_reset", Cpu_reset, 1'b1);
    check("rst_mem_we", Mem_we, 1'b0);
    check("rst_count", Count, 0);
    check("rst_loading", Loading, 1'b0);
    check("rst_done", Done, 1'b0);
    Reset = 1'b0;
    step(1);

    // Hand sequence: three words with latency check, then Finish back-fill.
    pulse_load();
    check("load_loading", Loading, 1'b1);
    check("load_cpu_reset", Cpu_reset, 1'b1);
    begin
      logic [DATA_W-1:0] words[3];
      words[0] = 8'hA3; words[1] = 8'h5F; words[2] = 8'h01;
      for (int w = 0; w < 3; w++) begin
        Input = words[w];
        Enter = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
          step(1);
          lat++;
          if (Mem_we === 1'b1) break;
        end
        check("enter_latency", lat, 3);
        check("enter_addr", Mem_addr, w);
        check("enter_data", Mem_data, words[w]);
        exp_q.push_back('{addr: ADDR_W'(w), data: words[w]});
        Enter = 1'b0;
        step(3);
      end
    end
    for (int a = 3; a < DEPTH; a++) exp_q.push_back('{addr: ADDR_W'(a), data: FILL});
    pulse_finish();
    wait_done("hand3");
    check("hand3_count", Count, 3);
    check("hand3_cpu_reset", Cpu_reset, 1'b0);
    compare_writes("hand3");

    // Table-driven loads with random data.
    for (int v = 0; v < 5; v++) begin
      pulse_load();
      for (int i = 0; i < vecs[v].n_words; i++) begin
        d = DATA_W'($urandom);
        if (vecs[v].n_words == DEPTH) d = DATA_W'(i) ^ 8'hFF;
        exp_q.push_back('{addr: ADDR_W'(i), data: d});
        press_word(d);
      end
      if (vecs[v].finish) begin
        for (int a = vecs[v].n_words; a < DEPTH; a++)
          exp_q.push_back('{addr: ADDR_W'(a), data: FILL});
        pulse_finish();
      end
      wait_done($sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), Count, vecs[v].exp_count);
      check($sformatf("vec%0d_loading", v), Loading, 1'b0);
      check($sformatf("vec%0d_total", v), obs_q.size(), vecs[v].exp_writes);
      compare_writes($sformatf("vec%0d", v));
    end

    // Enter held for 50 cycles with Input changing: one write of the value at the capture edge.
    pulse_load();
    for (int i = 0; i < 50; i++) hold_v[i] = DATA_W'($urandom);
    Enter = 1'b1;
    for (int i = 0; i < 50; i++) begin
      Input = hold_v[i];
      step(1);
    end
    check("hold_nwrites", obs_q.size(), 1);
    if (obs_q.size() > 0) check("hold_data", obs_q[0].data, hold_v[2]);
    Enter = 1'b0;
    step(3);
    // Enter and Finish on the same cycle: the data write wins, no fill starts.
    Input = 8'h3C;
    Enter = 1'b1; Finish = 1'b1;
    step(1);
    Enter = 1'b0; Finish = 1'b0;
    step(10);
    check("simul_nwrites", obs_q.size(), 2);
    if (obs_q.size() > 1) check("simul_data", {obs_q[1].addr, obs_q[1].data}, {5'd1, 8'h3C});
    check("simul_loading", Loading, 1'b1);
    check("simul_count", Count, 2);
    pulse_finish();
    wait_done("simul");
    check("simul_total", obs_q.size(), 32);

    // Asynchronous reset in the middle of a back-fill.
    pulse_load();
    pulse_finish();
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (Mem_we === 1'b1 && Mem_addr == 10) begin
        found = 1'b1;
        break;
      end
    end
    check("fill_reached_10", found, 1'b1);
    #2 Reset = 1'b1;
    #1;
    check("async_mem_we", Mem_we, 1'b0);
    check("async_cpu_reset", Cpu_reset, 1'b1);
    check("async_loading", Loading, 1'b0);
    check("async_addr", Mem_addr, 0);
    step(1);
    Reset = 1'b0;
    obs_q.delete();
    step(40);
    check("post_reset_writes", obs_q.size(), 0);
    check("post_reset_done", Done, 1'b0);

    // Run without loading, then reload from RUN.
    Run_req = 1'b1;
    step(1);
    Run_req = 1'b0;
    check("run_done", Done, 1'b1);
    check("run_cpu_reset", Cpu_reset, 1'b0);
    check("run_writes", obs_q.size(), 0);
    pulse_load();
    check("reload_cpu_reset", Cpu_reset, 1'b1);
    check("reload_loading", Loading, 1'b1);
    check("reload_done", Done, 1'b0);
    press_word(8'h77);
    check("reload_nwrites", obs_q.size(), 1);
    if (obs_q.size() > 0) check("reload_first", {obs_q[0].addr, obs_q[0].data}, {5'd0, 8'h77});
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    Load_req = 1'b1; Run_req = 1'b1;
    step(1);
    Load_req = 1'b0; Run_req = 1'b0;
    check("prio_loading", Loading, 1'b1);
    check("prio_done", Done, 1'b0);
    step(2);

    check("we_outside_loading", bad_we, 0);
    check("cpu_reset_vs_done", bad_rst, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ec2_program_loader.md
Name: ec2_program_loader

Overview:
Front-end sequencer that fills the EC2 processor's 32x8 instruction/data memory from the 8-bit Input switches and Enter key, then releases the processor to run. It owns the datapath memory write port during loading and holds the CPU (CU + DP) in reset until the program is complete. Unused words are back-filled with a fixed value so every run starts from a deterministic memory image.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 8, memory word / Input width
DEPTH, 32, number of memory words (must equal 2**ADDR_W)
SYNC_STAGES, 2, flip-flop stages synchronising Enter and Finish
FILL_VALUE, 8'h00, word written to every address not loaded by the user

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Load_req  input  1  synchronous pulse/level: start a new load
Run_req  input  1  synchronous pulse/level: run existing memory without loading
Enter  input  1  raw pushbutton: commit Input as next word
Finish  input  1  raw pushbutton: end loading early, back-fill the rest
Input  input  DATA_W  word to be written
Mem_we  output  1  memory write enable (one cycle per word)
Mem_addr  output  ADDR_W  memory write address
Mem_data  output  DATA_W  memory write data
Cpu_reset  output  1  high holds CU and DP in reset
Loading  output  1  high in WAIT_PRESS, WRITE, WAIT_RELEASE, FILL
Done  output  1  high in RUN
Count  output  ADDR_W+1  words written by user in current load (0..DEPTH)

Behaviour:
- Reset (async, any state): state=IDLE; Mem_we=0, Mem_addr=0, Mem_data=0, Cpu_reset=1, Loading=0, Done=0, Count=0; synchroniser and edge-detect flops cleared. A load in progress is abandoned; no further writes.
- Enter/Finish: each passes through SYNC_STAGES flops, then a rising-edge detector. A raw input first sampled high at edge k produces an edge event evaluated at edge k+SYNC_STAGES.
- States:
  IDLE: Cpu_reset=1. Load_req -> WAIT_PRESS (Mem_addr=0, Count=0). Else Run_req -> RUN. Load_req has priority over Run_req.
  WAIT_PRESS: Enter edge -> WRITE, registering Input into Mem_data at that edge. Else Finish edge -> FILL. Enter has priority; a simultaneous Finish is discarded.
  WRITE (1 cycle): Mem_we=1 at Mem_addr/Mem_data. On exit, Count+=1. If Mem_addr==DEPTH-1 -> RUN. Otherwise Mem_addr+=1 and -> WAIT_RELEASE.
  WAIT_RELEASE: stays until synchronised Enter is low, then -> WAIT_PRESS. A held key writes exactly one word.
  FILL: Mem_we=1 each cycle, Mem_data=FILL_VALUE, from the current Mem_addr up to DEPTH-1; Mem_addr+=1 per cycle; after writing DEPTH-1 -> RUN. Count is unchanged.
  RUN: Cpu_reset=0, Done=1, Mem_we=0. Load_req -> WAIT_PRESS (Cpu_reset=1 next cycle, Mem_addr=0, Count=0). Run_req is ignored.
- Load_req and Run_req are ignored in every loading state.
- Cpu_reset=1 in all states except RUN; Mem_we never asserts in IDLE or RUN.
- Mem_addr never wraps: maximum is DEPTH-1. Count saturates at DEPTH.
- Finish pressed with Mem_addr=0 fills all DEPTH words.
- Input is sampled only at the edge entering WRITE; changes elsewhere have no effect.

Test Plan:
1. Assert Reset mid-cycle, asynchronously -> outputs immediately at reset values: Cpu_reset=1, Mem_we=0, Count=0, state IDLE.
2. Load_req; Enter with Input=8'hA3, 8'h5F, 8'h01 (release between) -> three Mem_we pulses at addr 0,1,2 with those data, each 3 cycles after raw Enter; Finish -> 29 consecutive writes of 8'h00 at addr 3..31; then Done=1, Cpu_reset=0, Count=3.
3. Load 32 words (data = addr^8'hFF) without Finish -> last write at addr 31 goes straight to RUN; no FILL writes; Count=32.
4. Hold Enter high for 50 cycles with Input changing -> exactly one write, with the data present at the capture edge. Pulse Enter and Finish simultaneously -> one data write, no fill.
5. Assert Reset during FILL at addr 10 -> Mem_we drops asynchronously; IDLE; no further writes after reset release.
6. From IDLE, Run_req -> RUN in 1 cycle with no writes. In RUN, Load_req -> Cpu_reset=1 and Loading=1; next Enter writes addr 0. Load_req+Run_req together in IDLE -> WAIT_PRESS.
